// File: rtl/rr_merge2.sv
// Two-channel round-robin merger feeding the 2:1 mux stage: registers the winning
// word together with its source channel, bounding each ownership to MAX_BURST words.
module rr_merge2 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             sel,
    input  logic             out_ready,
    // Observation of internal state: 0 = IDLE, 1 = OWN0, 2 = OWN1.
    output logic [1:0]       dbg_state,
    output logic [3:0]       dbg_burst_cnt,
    output logic             dbg_last
);

    // Valid/ready: a word moves on a port exactly in the cycle where both valid and
    // ready are high at the rising edge; valid never depends on ready, and a ready
    // output depends only on state and out_ready, never on its own valid input.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_END = 4'(MAX_BURST);

    state_t     state;
    logic       last;
    logic [3:0] burst_cnt;

    logic load;
    logic own_ch;
    logic own_valid;
    logic other_valid;
    logic xfer;
    logic burst_done;

    assign load        = out_ready | ~out_valid;
    assign in0_ready   = load & (state == OWN0);
    assign in1_ready   = load & (state == OWN1);
    assign own_ch      = (state == OWN1);
    assign own_valid   = own_ch ? in1_valid : in0_valid;
    assign other_valid = own_ch ? in0_valid : in1_valid;
    assign xfer        = (in0_valid & in0_ready) | (in1_valid & in1_ready);
    assign burst_done  = (burst_cnt + 4'd1) == BURST_END;

    assign dbg_state     = state;
    assign dbg_burst_cnt = burst_cnt;
    assign dbg_last      = last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= own_ch ? in1_data : in0_data;
                sel       <= own_ch;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    burst_cnt <= 4'd0;
                    if (in0_valid & in1_valid) begin
                        state <= last ? OWN0 : OWN1;
                    end else if (in0_valid) begin
                        state <= OWN0;
                    end else if (in1_valid) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (xfer) begin
                        // Burst limit only hands over when the other side is waiting.
                        if (burst_done) begin
                            burst_cnt <= 4'd0;
                            if (other_valid) begin
                                state <= own_ch ? OWN0 : OWN1;
                                last  <= own_ch;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end else if (!own_valid) begin
                        burst_cnt <= 4'd0;
                        last      <= own_ch;
                        if (other_valid) begin
                            state <= own_ch ? OWN0 : OWN1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
